// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : load_store_unit_if
// Purpose   : Core-side request/response channel of the load/store unit.
// Revision  : 1.0
// ============================================================================
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/half/word/doubleword load-store unit over a 32 x 64-bit
//            memory; partial stores use read-modify-write.
// Revision : 1.0
// ============================================================================
module load_store_unit (
  input  wire logic        clk,
  input  wire logic        reset,
  load_store_unit_if.slave bus,
  output logic [4:0]       mem_address,
  output logic             mem_we,
  output logic [63:0]      mem_din,
  input  wire logic [63:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_wdata;
  logic [63:0] r_mem_din;
  logic [63:0] r_rdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;

  logic        w_misaligned;
  logic [7:0]  w_lane_mask;
  logic [5:0]  w_shift;
  logic [63:0] w_wdata_shift;
  logic [63:0] w_field;
  logic [63:0] w_merged;
  logic [63:0] w_load;

  // Alignment is judged on the incoming request, before capture.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_size)
      2'd0: w_misaligned = 1'b0;
      2'd1: w_misaligned = bus.req_addr[0];
      2'd2: w_misaligned = |bus.req_addr[1:0];
      2'd3: w_misaligned = |bus.req_addr[2:0];
    endcase
  end

  assign w_shift = {r_addr[2:0], 3'b000};

  always_comb begin
    w_lane_mask = 8'h00;
    case (r_size)
      2'd0: w_lane_mask = 8'h01 << r_addr[2:0];
      2'd1: w_lane_mask = 8'h03 << r_addr[2:0];
      2'd2: w_lane_mask = 8'h0F << r_addr[2:0];
      2'd3: w_lane_mask = 8'hFF;
    endcase
  end

  assign w_wdata_shift = r_wdata << w_shift;

  generate
    for (genvar k = 0; k < 8; k++) begin : g_lane
      assign w_merged[8*k +: 8] = w_lane_mask[k] ? w_wdata_shift[8*k +: 8]
                                                 : mem_dout[8*k +: 8];
    end
  endgenerate

  assign w_field = mem_dout >> w_shift;

  always_comb begin
    w_load = w_field;
    case (r_size)
      2'd0: w_load = {{56{~r_unsigned & w_field[7]}},  w_field[7:0]};
      2'd1: w_load = {{48{~r_unsigned & w_field[15]}}, w_field[15:0]};
      2'd2: w_load = {{32{~r_unsigned & w_field[31]}}, w_field[31:0]};
      2'd3: w_load = w_field;
    endcase
  end

  // Response outputs are registered on entry to RESP and cleared otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 8'd0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_wdata     <= 64'd0;
      r_mem_din   <= 64'd0;
      r_rdata     <= 64'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 64'd0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_addr     <= bus.req_addr;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
            if (w_misaligned) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_size == 2'd3) begin
              r_state   <= WRITE;
              r_mem_din <= bus.req_wdata;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          if (r_we) begin
            r_state   <= WRITE;
            r_mem_din <= w_merged;
          end else begin
            r_state     <= RESP;
            r_rdata     <= w_load;
            r_rsp_valid <= 1'b1;
          end
        end
        WRITE: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_rsp_err;

  assign mem_we      = (r_state == WRITE);
  assign mem_address = (r_state == READ || r_state == WRITE) ? r_addr[7:3] : 5'd0;
  assign mem_din     = r_mem_din;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  8  byte address; [7:3] doubleword index, [2:0] byte offset.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  input  64  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  64  extended load result; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned access flag, valid with rsp_valid.
REQ-014 mem_address  output  5  doubleword index to data memory.
REQ-015 mem_we  output  1  data-memory write enable.
REQ-016 mem_din  output  64  data-memory write data.
REQ-017 mem_dout  input  64  data-memory read data, combinational from mem_address.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid & req_ready; all req_* fields captured into internal registers at that edge.
REQ-020 Misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0) SHALL go IDLE->RESP with rsp_err=1; no memory access, mem_we never asserted.
REQ-021 Aligned load SHALL go IDLE->READ->RESP; mem_dout sampled at end of READ.
REQ-022 Aligned doubleword store SHALL go IDLE->WRITE->RESP; mem_din = captured wdata.
REQ-023 Aligned byte/half/word store SHALL go IDLE->READ->WRITE->RESP (read-modify-write).
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; no response backpressure.
REQ-025 Latency from acceptance edge T: error rsp at T+1; load and double store rsp at T+2; partial store rsp at T+3.
REQ-026 mem_address SHALL equal the captured addr[7:3] in READ and WRITE; 0 otherwise.
REQ-027 mem_we SHALL be 1 only in WRITE, decoded combinationally from state.
REQ-028 Byte lanes are little-endian: lane k = bits [8k+7:8k], selected from offset addr[2:0].
REQ-029 Partial store merge: mem_din = old doubleword with the 1/2/4 addressed lanes replaced by the low 8/16/32 bits of wdata; other lanes unchanged.
REQ-030 Load result: addressed field shifted to bit 0, extended to 64 bits per req_unsigned; doubleword loads return the word unmodified.
REQ-031 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-032 A new request SHALL NOT be accepted in the same cycle as rsp_valid; next acceptance is the IDLE cycle after RESP.

Reset
REQ-033 On reset assertion state SHALL go to IDLE immediately; mem_we, rsp_valid, rsp_err=0; rsp_rdata, mem_address, mem_din=0; captured request registers cleared.
REQ-034 Reset during READ or WRITE SHALL abort the request with no response; mem_we drops asynchronously, no further write occurs.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-036 Memory word 3 = 0x1122334455667788; load byte addr 0x1F signed -> rsp at T+2, rdata 0x0000000000000011; same at addr 0x18 -> 0xFFFFFFFFFFFFFF88 signed, 0x88 unsigned.
REQ-037 Store half 0xBEEF to addr 0x1A over word 3 above -> READ, WRITE, rsp at T+3; word 3 becomes 0x11223344BEEF7788, rdata 0, err 0.
REQ-038 Store double 0xDEADBEEFCAFEF00D to addr 0x40 -> mem_we high exactly one cycle with mem_address 8, rsp at T+2; a subsequent load double returns the value.
REQ-039 Load word at addr 0x06 -> rsp at T+1 with rsp_err=1, rdata 0, mem_we never high.
REQ-040 Assert reset while in WRITE of a partial store -> mem_we falls immediately, no rsp_valid, memory unchanged, req_ready=1 after reset deassertion.
REQ-041 Back-to-back requests with req_valid held high -> req_ready low from acceptance through RESP; second request accepted the cycle after rsp_valid.
